// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 3-stage pipelined floating-point adder/subtractor
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands valid          in_ready  pipeline accepts input
//   in_a/in_b  operands {sign,exp,man} in_sub    1 = A-B, 0 = A+B
//   in_tag     sideband returned with the result
//   out_valid  result valid            out_ready downstream accepts result
//   out_res    result {sign,exp,man}   out_tag   tag of this result
//   out_flags  {invalid, overflow, underflow_ftz, inexact}
//
// Build option: FP_ADD_ROUND_RNE_EN selects round-to-nearest-even;
// without it results are truncated (round toward zero).

module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_sub,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_res,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags
);

  localparam int W     = EXP_W + MAN_W + 1;
  localparam int SIG_W = MAN_W + 4;          // hidden, mantissa, guard, round, sticky
  localparam int XE_W  = EXP_W + 2;          // signed working exponent
  localparam int LZ_W  = $clog2(SIG_W + 1);

  localparam logic [EXP_W-1:0]        EXP_MAX   = '1;
  localparam logic [EXP_W-1:0]        FAR_SHIFT = EXP_W'(MAN_W + 3);
  localparam logic signed [XE_W-1:0]  XE_ZERO   = '0;
  localparam logic signed [XE_W-1:0]  XE_ONE    = XE_W'(1);
  localparam logic signed [XE_W-1:0]  XE_EMAX   = {2'b00, EXP_MAX};
  localparam logic [W-1:0]            QNAN      = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  // Whole pipe moves together; no bubble collapsing.
  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
    logic [LZ_W-1:0] n;
    logic            done;
    n    = LZ_W'(SIG_W);
    done = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!done && v[i]) begin
        n    = LZ_W'(SIG_W - 1 - i);
        done = 1'b1;
      end
    end
    return n;
  endfunction

  // ---------------- stage 1: unpack, classify, swap, align ----------------
  logic             a_s, b_s, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge_b;
  logic [EXP_W-1:0] a_e, b_e, l_e, s_e, e_diff;
  logic [W-2:0]     a_mag, b_mag;
  logic [SIG_W-1:0] a_sig, b_sig, l_sig, s_sig, s_align;
  logic [2*SIG_W-1:0] s_ext;
  logic             l_s, s_s;

  always_comb begin
    a_s    = in_a[W-1];
    b_s    = in_b[W-1] ^ in_sub;
    a_e    = in_a[W-2:MAN_W];
    b_e    = in_b[W-2:MAN_W];
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_nan  = (a_e == EXP_MAX) && (in_a[MAN_W-1:0] != '0);
    b_nan  = (b_e == EXP_MAX) && (in_b[MAN_W-1:0] != '0);
    a_inf  = (a_e == EXP_MAX) && (in_a[MAN_W-1:0] == '0);
    b_inf  = (b_e == EXP_MAX) && (in_b[MAN_W-1:0] == '0);
    // Subnormals flush to zero before the magnitude compare.
    a_mag  = a_zero ? '0 : in_a[W-2:0];
    b_mag  = b_zero ? '0 : in_b[W-2:0];
    a_sig  = a_zero ? '0 : {1'b1, in_a[MAN_W-1:0], 3'b000};
    b_sig  = b_zero ? '0 : {1'b1, in_b[MAN_W-1:0], 3'b000};
    a_ge_b = (a_mag >= b_mag);
    l_s    = a_ge_b ? a_s   : b_s;
    s_s    = a_ge_b ? b_s   : a_s;
    l_e    = a_ge_b ? a_e   : b_e;
    s_e    = a_ge_b ? b_e   : a_e;
    l_sig  = a_ge_b ? a_sig : b_sig;
    s_sig  = a_ge_b ? b_sig : a_sig;
    e_diff = l_e - s_e;
    // Upper half is the aligned value, lower half is everything shifted out.
    s_ext  = {s_sig, {SIG_W{1'b0}}} >> e_diff;
    if (e_diff >= FAR_SHIFT) begin
      s_align = {{(SIG_W-1){1'b0}}, |s_sig};
    end else begin
      s_align = {s_ext[2*SIG_W-1:SIG_W+1], s_ext[SIG_W] | (|s_ext[SIG_W-1:0])};
    end
  end

  logic             s1_valid, s1_sign, s1_sub, s1_nan, s1_inf, s1_inf_sign, s1_zero_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_l_sig, s1_s_sig;
  logic [TAG_W-1:0] s1_tag;

  // ---------------- stage 2: significand add/subtract ----------------
  logic [SIG_W:0]   sum;
  assign sum = s1_sub ? ({1'b0, s1_l_sig} - {1'b0, s1_s_sig})
                      : ({1'b0, s1_l_sig} + {1'b0, s1_s_sig});

  logic             s2_valid, s2_sign, s2_nan, s2_inf, s2_inf_sign, s2_zero_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [SIG_W:0]   s2_sum;
  logic [TAG_W-1:0] s2_tag;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZ_W-1:0]         lz;
  logic [SIG_W-1:0]        norm;
  logic signed [XE_W-1:0]  n_exp, r_exp;
  logic [MAN_W+1:0]        rnd;
  logic [MAN_W-1:0]        r_man;
  logic                    inx;
  logic [W-1:0]            res;
  logic [3:0]              flags;

  always_comb begin
    lz = '0;
    if (s2_sum[SIG_W]) begin
      // Carry out: drop one bit into sticky.
      norm  = {s2_sum[SIG_W:2], s2_sum[1] | s2_sum[0]};
      n_exp = $signed({2'b00, s2_exp}) + XE_ONE;
    end else begin
      lz    = lzc(s2_sum[SIG_W-1:0]);
      norm  = s2_sum[SIG_W-1:0] << lz;
      n_exp = $signed({2'b00, s2_exp}) - $signed(XE_W'(lz));
    end
    inx = |norm[2:0];
`ifdef FP_ADD_ROUND_RNE_EN
    rnd = {1'b0, norm[SIG_W-1:3]}
          + {{(MAN_W+1){1'b0}}, norm[2] & (norm[1] | norm[0] | norm[3])};
`else
    rnd = {1'b0, norm[SIG_W-1:3]};
`endif
    if (rnd[MAN_W+1]) begin
      r_exp = n_exp + XE_ONE;
      r_man = rnd[MAN_W:1];
    end else begin
      r_exp = n_exp;
      r_man = rnd[MAN_W-1:0];
    end

    res   = {s2_sign, r_exp[EXP_W-1:0], r_man};
    flags = {3'b000, inx};
    if (s2_nan) begin
      res   = QNAN;
      flags = 4'b1000;
    end else if (s2_inf) begin
      res   = {s2_inf_sign, EXP_MAX, {MAN_W{1'b0}}};
      flags = 4'b0000;
    end else if (s2_sum == '0) begin
      res   = {s2_zero_sign, {(W-1){1'b0}}};
      flags = 4'b0000;
    end else if (n_exp <= XE_ZERO) begin
      res   = {s2_sign, {(W-1){1'b0}}};
      flags = 4'b0011;
    end else if (r_exp >= XE_EMAX) begin
      res   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      flags = 4'b0101;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign      <= l_s;
        s1_sub       <= l_s ^ s_s;
        s1_exp       <= l_e;
        s1_l_sig     <= l_sig;
        s1_s_sig     <= s_align;
        s1_nan       <= a_nan | b_nan | (a_inf & b_inf & (a_s ^ b_s));
        s1_inf       <= a_inf | b_inf;
        s1_inf_sign  <= a_inf ? a_s : b_s;
        s1_zero_sign <= a_zero & b_zero & a_s & b_s;
        s1_tag       <= in_tag;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign      <= s1_sign;
        s2_exp       <= s1_exp;
        s2_sum       <= sum;
        s2_nan       <= s1_nan;
        s2_inf       <= s1_inf;
        s2_inf_sign  <= s1_inf_sign;
        s2_zero_sign <= s1_zero_sign;
        s2_tag       <= s1_tag;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_res   <= res;
        out_tag   <= s2_tag;
        out_flags <= flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - directed self-checking bench for fp_add_pipe

module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  int checks = 0;
  int passes = 0;

`ifdef FP_ADD_ROUND_RNE_EN
  localparam logic [31:0] ONE_PLUS_1P5ULP = 32'h3F800001;
`else
  localparam logic [31:0] ONE_PLUS_1P5ULP = 32'h3F800000;
`endif

  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Issue one op on an idle pipe and wait (bounded) for its result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [3:0] tag, output logic [31:0] res,
                        output logic [3:0] rtag, output logic [3:0] flg, output int lat);
    in_a = a; in_b = b; in_sub = sub; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_res; rtag = out_tag; flg = out_flags;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_res !== 32'h0) $display("FAIL reset out_res got %h want 00000000", out_res); else passes++;
    checks++; if (out_tag !== 4'h0) $display("FAIL reset out_tag got %h want 0", out_tag); else passes++;
    checks++; if (out_flags !== 4'h0) $display("FAIL reset out_flags got %b want 0000", out_flags); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string name, input logic [31:0] va[], input logic [31:0] vb[],
                           input logic vs[], input logic [31:0] vr[], input logic [3:0] vf[]);
    logic [31:0] r;
    logic [3:0]  t, f;
    int          lat;
    for (int i = 0; i < va.size(); i++) begin
      run_op(va[i], vb[i], vs[i], 4'(i + 5), r, t, f, lat);
      checks++; if (lat !== 3) $display("FAIL %s[%0d] latency got %0d want 3", name, i, lat); else passes++;
      checks++; if (r !== vr[i]) $display("FAIL %s[%0d] res got %h want %h", name, i, r, vr[i]); else passes++;
      checks++; if (f !== vf[i]) $display("FAIL %s[%0d] flags got %b want %b", name, i, f, vf[i]); else passes++;
      checks++; if (t !== 4'(i + 5)) $display("FAIL %s[%0d] tag got %h want %h", name, i, t, 4'(i + 5)); else passes++;
    end
  endtask

  task automatic test_arith();
    logic [31:0] va[] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h40000000, 32'h00000001, 32'h40000000, 32'h40400000};
    logic [31:0] vb[] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic        vs[] = '{1'b0,         1'b1,         1'b0,         1'b1,         1'b0,         1'b0,         1'b1};
    logic [31:0] vr[] = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h40800000, 32'h40000000};
    logic [3:0]  vf[] = '{4'b0000,      4'b0000,      4'b0000,      4'b0000,      4'b0000,      4'b0000,      4'b0000};
    run_table("arith", va, vb, vs, vr, vf);
  endtask

  task automatic test_specials();
    logic [31:0] va[] = '{32'h7F800000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'h3F800000};
    logic [31:0] vb[] = '{32'hFF800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800001, 32'h3F800000, 32'h7F800000};
    logic        vs[] = '{1'b0,         1'b0,         1'b0,         1'b1,         1'b0,         1'b1};
    logic [31:0] vr[] = '{32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h7F800000, 32'hFF800000};
    logic [3:0]  vf[] = '{4'b1000,      4'b1000,      4'b0101,      4'b0011,      4'b0000,      4'b0000};
    run_table("special", va, vb, vs, vr, vf);
  endtask

  task automatic test_rounding();
    logic [31:0] va[] = '{32'h3F800000,    32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vb[] = '{32'h33C00000,    32'h33800000, 32'h00800000, 32'h33800000};
    logic        vs[] = '{1'b0,            1'b0,         1'b0,         1'b1};
    logic [31:0] vr[] = '{ONE_PLUS_1P5ULP, 32'h3F800000, 32'h3F800000, 32'h3F7FFFFF};
    logic [3:0]  vf[] = '{4'b0001,         4'b0001,      4'b0001,      4'b0000};
    run_table("round", va, vb, vs, vr, vf);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[8] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h7F800000,
                           32'h3F800000, 32'h80000000, 32'h40000000, 32'h40400000};
    logic [31:0] vb[8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFF800000,
                           32'h33C00000, 32'h80000000, 32'h40000000, 32'h3F800000};
    logic        vs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vr[8] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h7FC00000,
                           ONE_PLUS_1P5ULP, 32'h80000000, 32'h40800000, 32'h40000000};
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 8 && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = va[sent]; in_b = vb[sent]; in_sub = vs[sent]; in_tag = 4'(sent);
      end
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b stall in_ready cyc %0d got %b want 0", cyc, in_ready); else passes++;
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b stall out_valid cyc %0d got %b want 1", cyc, out_valid); else passes++;
        checks++; if (out_res !== vr[got]) $display("FAIL b2b stall hold res cyc %0d got %h want %h", cyc, out_res, vr[got]); else passes++;
        checks++; if (out_tag !== 4'(got)) $display("FAIL b2b stall hold tag cyc %0d got %h want %h", cyc, out_tag, 4'(got)); else passes++;
      end
      if (out_valid && out_ready) begin
        checks++; if (out_res !== vr[got]) $display("FAIL b2b res[%0d] got %h want %h", got, out_res, vr[got]); else passes++;
        checks++; if (out_tag !== 4'(got)) $display("FAIL b2b tag[%0d] got %h want %h", got, out_tag, 4'(got)); else passes++;
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 8) $display("FAIL b2b results got %0d want 8", got); else passes++;
    checks++; if (cyc !== 14) $display("FAIL b2b cycles got %0d want 14", cyc); else passes++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    out_ready = 1'b1;
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0;
    in_valid = 1'b1; in_tag = 4'hA;
    @(posedge clk); #1;
    in_tag = 4'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst out_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_tag !== 4'h0) $display("FAIL midrst out_tag got %h want 0", out_tag); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst in_ready got %b want 1", in_ready); else passes++;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL midrst stale results got %0d want 0", seen); else passes++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_specials();
    test_rounding();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
